// File: rtl/sram_stream_master.sv
// Purpose : command-driven DMA master. It turns one (address, length, direction)
//           command into back-to-back accesses on the 16-bit SRAM controller port.
// Latency : the first access appears 2 cycles after the command is accepted.
//           A read word lands in the FIFO READ_LATENCY cycles after its sram_read.
// Backpressure: reads are issued only while FIFO space is guaranteed for every
//           outstanding word. Writes follow the wr_valid/wr_ready handshake, so
//           gaps in the write stream become idle SRAM cycles.
// Ports   : clk/reset (sync, active-high); cmd_* command handshake; rd_* read
//           stream out of the FIFO; wr_* write stream in; busy/done status;
//           sram_* registered controller interface plus sram_readdata return.
module sram_stream_master #(
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 8,
  parameter int ADDR_W       = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [15:0]       rd_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [15:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] sram_address,
  output logic [1:0]        sram_byteenable,
  output logic              sram_chipselect,
  output logic              sram_read,
  output logic              sram_write,
  output logic [15:0]       sram_writedata,
  input  logic [15:0]       sram_readdata
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int DW = $clog2(READ_LATENCY) + 1;

  localparam logic [CW-1:0]     DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW:0]       DEPTH_W = (CW+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

  typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_DRAIN, WR} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] remaining_q;
  logic [DW-1:0]     drain_cnt_q;
  logic              busy_q;
  logic              done_q;
  logic [ADDR_W-1:0] sram_address_q;
  logic [1:0]        sram_byteenable_q;
  logic              sram_chipselect_q;
  logic              sram_read_q;
  logic              sram_write_q;
  logic [15:0]       sram_writedata_q;

  // One bit per read travelling through the controller. The tail bit marks the
  // cycle in which sram_readdata carries that read's word.
  logic [READ_LATENCY-1:0] rd_pipe_q;

  logic [15:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          push;
  logic          pop;
  logic [CW-1:0] inflight;
  logic          credit_ok;
  logic          issue_rd;
  logic          wr_hs;

  assign cmd_ready = (state_q == IDLE) && !reset;
  assign wr_ready  = (state_q == WR) && (remaining_q != '0);
  assign wr_hs     = wr_valid && wr_ready;

  assign busy            = busy_q;
  assign done            = done_q;
  assign sram_address    = sram_address_q;
  assign sram_byteenable = sram_byteenable_q;
  assign sram_chipselect = sram_chipselect_q;
  assign sram_read       = sram_read_q;
  assign sram_write      = sram_write_q;
  assign sram_writedata  = sram_writedata_q;

  // A read sitting in the output register has been committed but has not
  // entered rd_pipe_q yet, so it must be counted too. Otherwise one extra read
  // slips through and the FIFO overflows by one word.
  always_comb begin
    inflight = CW'(sram_read_q);
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + CW'(rd_pipe_q[i]);
    end
  end

  // A pop in the same cycle is ignored, which is conservative.
  assign credit_ok = ({1'b0, count_q} + {1'b0, inflight}) < DEPTH_W;
  assign issue_rd  = (state_q == RD_ISSUE) && (remaining_q != '0) && credit_ok;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= IDLE;
      addr_q            <= '0;
      remaining_q       <= '0;
      drain_cnt_q       <= '0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      sram_address_q    <= '0;
      sram_byteenable_q <= 2'b00;
      sram_chipselect_q <= 1'b0;
      sram_read_q       <= 1'b0;
      sram_write_q      <= 1'b0;
      sram_writedata_q  <= '0;
    end else begin
      done_q            <= 1'b0;
      sram_byteenable_q <= 2'b00;
      sram_chipselect_q <= 1'b0;
      sram_read_q       <= 1'b0;
      sram_write_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            addr_q      <= cmd_addr;
            remaining_q <= cmd_len;
            if (cmd_len == '0) begin
              done_q <= 1'b1;
            end else begin
              busy_q  <= 1'b1;
              state_q <= cmd_write ? WR : RD_ISSUE;
            end
          end
        end
        RD_ISSUE: begin
          if (issue_rd) begin
            sram_chipselect_q <= 1'b1;
            sram_read_q       <= 1'b1;
            sram_byteenable_q <= 2'b11;
            sram_address_q    <= addr_q;
            addr_q            <= addr_q + ONE_A;
            remaining_q       <= remaining_q - ONE_A;
            if (remaining_q == ONE_A) begin
              state_q     <= RD_DRAIN;
              drain_cnt_q <= DW'(READ_LATENCY - 1);
            end
          end
        end
        RD_DRAIN: begin
          // Reads return in order. done rises in the cycle the final word is
          // written into the FIFO, READ_LATENCY cycles after the last sram_read.
          if (drain_cnt_q == '0) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            drain_cnt_q <= drain_cnt_q - DW'(1);
          end
        end
        WR: begin
          if (wr_hs) begin
            sram_chipselect_q <= 1'b1;
            sram_write_q      <= 1'b1;
            sram_byteenable_q <= 2'b11;
            sram_address_q    <= addr_q;
            sram_writedata_q  <= wr_data;
            addr_q            <= addr_q + ONE_A;
            remaining_q       <= remaining_q - ONE_A;
            // done/busy change together with the final sram_write.
            if (remaining_q == ONE_A) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // ------------------------------------------------- read return tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pipe_q <= '0;
    end else begin
      rd_pipe_q[0] <= sram_read_q;
      for (int i = 1; i < READ_LATENCY; i++) begin
        rd_pipe_q[i] <= rd_pipe_q[i-1];
      end
    end
  end

  // ---------------------------------------------------------- read FIFO
  assign push     = rd_pipe_q[READ_LATENCY-1];
  assign pop      = (count_q != '0) && rd_ready;
  assign rd_valid = (count_q != '0);
  assign rd_data  = fifo_mem[rptr_q];

  always_comb begin
    wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      fifo_mem[wptr_q] <= sram_readdata;
    end
  end

  // The read credit scheme guarantees that a word always finds room.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      assert (count_q != DEPTH_C);
    end
  end

endmodule

// File: tb/tb_sram_stream_master.sv
module tb_sram_stream_master;

  localparam int ADDR_W = 18;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr, cmd_len;
  logic              rd_valid, rd_ready;
  logic [15:0]       rd_data;
  logic              wr_valid, wr_ready;
  logic [15:0]       wr_data;
  logic              busy, done;
  logic [ADDR_W-1:0] sram_address;
  logic [1:0]        sram_byteenable;
  logic              sram_chipselect, sram_read, sram_write;
  logic [15:0]       sram_writedata, sram_readdata;

  sram_stream_master #(.READ_LATENCY(2), .FIFO_DEPTH(8), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .busy(busy), .done(done),
    .sram_address(sram_address), .sram_byteenable(sram_byteenable),
    .sram_chipselect(sram_chipselect), .sram_read(sram_read),
    .sram_write(sram_write), .sram_writedata(sram_writedata),
    .sram_readdata(sram_readdata)
  );

  always #5 clk = ~clk;

  // SRAM model: 2-cycle read latency, each word holds its own address.
  logic [ADDR_W-1:0] mdl_a0, mdl_a1;
  always @(posedge clk) begin
    mdl_a1 <= mdl_a0;
    mdl_a0 <= sram_address;
  end
  assign sram_readdata = mdl_a1[15:0];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboards
  logic [ADDR_W-1:0]  exp_rd_addr[$];
  logic [15:0]        exp_rd_data[$];
  logic [ADDR_W+15:0] exp_wr[$];
  int                 wr_cycs[$];

  int rd_total = 0, wr_total = 0, done_cnt = 0, cs_cnt = 0;
  int both_cnt = 0, cs_bad = 0;
  int first_rd_cyc = -1, last_rd_cyc = -1, done_cyc = -1;
  logic busy_at_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fail(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: unexpected event at cycle %0d", tag, cyc);
  endtask

  // Monitor samples on the falling edge.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (sram_read && sram_write) both_cnt++;
      if (sram_chipselect !== (sram_read || sram_write)) cs_bad++;
      if (sram_chipselect) cs_cnt++;
      if (sram_read) begin
        rd_total++;
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        last_rd_cyc = cyc;
        check("rd_be", sram_byteenable, 2'b11);
        if (exp_rd_addr.size() == 0) fail("rd_addr_extra");
        else check("rd_addr", sram_address, exp_rd_addr.pop_front());
      end
      if (sram_write) begin
        logic [ADDR_W+15:0] e;
        wr_total++;
        wr_cycs.push_back(cyc);
        if (exp_wr.size() == 0) fail("wr_extra");
        else begin
          e = exp_wr.pop_front();
          check("wr_addr", sram_address, e[ADDR_W+15:16]);
          check("wr_data", sram_writedata, e[15:0]);
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        busy_at_done = busy;
      end
      if (rd_valid && rd_ready) begin
        if (exp_rd_data.size() == 0) fail("rd_data_extra");
        else check("rd_data", rd_data, exp_rd_data.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic wr, input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] len);
    int n = 0;
    logic [ADDR_W-1:0] ai;
    if (!wr) begin
      for (int i = 0; i < int'(len); i++) begin
        ai = a + ADDR_W'(i);
        exp_rd_addr.push_back(ai);
        exp_rd_data.push_back(ai[15:0]);
      end
    end
    cmd_write = wr; cmd_addr = a; cmd_len = len; cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!cmd_ready) fail("cmd_accept_timeout");
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input int bound);
    int n = 0;
    while (done_cnt < target && n < bound) begin
      n++;
      tick();
    end
    check("done_seen", done_cnt, target);
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while (exp_rd_data.size() != 0 && n < bound) begin
      n++;
      tick();
    end
    check("rd_drained", exp_rd_data.size(), 0);
  endtask

  initial begin
    int base, dbase, csbase, n;
    logic [15:0] wd[3];
    logic        pat[4];
    int          k;

    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    rd_ready = 1'b0; wr_valid = 1'b0; wr_data = '0;

    // ---- reset state
    repeat (2) tick();
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_cs", sram_chipselect, 0);
    check("rst_read", sram_read, 0);
    check("rst_write", sram_write, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_wr_ready", wr_ready, 0);
    reset = 1'b0;
    #1;
    check("idle_cmd_ready", cmd_ready, 1);

    // ---- read of 4 words at 0x10
    rd_ready = 1'b1;
    base = rd_total; first_rd_cyc = -1;
    send_cmd(1'b0, 18'h00010, 18'd4);
    wait_done(1, 50);
    check("t1_reads", rd_total - base, 4);
    check("t1_back_to_back", last_rd_cyc - first_rd_cyc, 3);
    check("t1_done_lat", done_cyc - last_rd_cyc, 2);
    wait_drain(20);
    tick();
    check("t1_rd_valid_low", rd_valid, 0);
    check("t1_busy_low", busy, 0);

    // ---- read of 20 words with the sink stalled
    rd_ready = 1'b0;
    base = rd_total; dbase = done_cnt;
    send_cmd(1'b0, 18'h00100, 18'd20);
    repeat (40) tick();
    check("t2_stall_reads", rd_total - base, 8);
    check("t2_rd_valid", rd_valid, 1);
    check("t2_busy", busy, 1);
    check("t2_no_done", done_cnt - dbase, 0);
    rd_ready = 1'b1;
    wait_done(dbase + 1, 200);
    wait_drain(50);
    repeat (5) tick();
    check("t2_reads", rd_total - base, 20);
    check("t2_done_once", done_cnt - dbase, 1);

    // ---- write of 3 words wrapping the address space, valid pattern 1,0,1,1
    wd[0] = 16'hA001; wd[1] = 16'hB002; wd[2] = 16'hC003;
    exp_wr.push_back({18'h3FFFE, wd[0]});
    exp_wr.push_back({18'h3FFFF, wd[1]});
    exp_wr.push_back({18'h00000, wd[2]});
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b1;
    base = wr_total; dbase = done_cnt; wr_cycs.delete();
    send_cmd(1'b1, 18'h3FFFE, 18'd3);
    k = 0;
    for (int i = 0; i < 4; i++) begin
      wr_valid = pat[i];
      wr_data  = wd[k];
      @(negedge clk);
      if (pat[i]) begin
        check("t3_wr_ready", wr_ready, 1);
        k++;
      end
      tick();
    end
    wr_valid = 1'b0;
    wait_done(dbase + 1, 20);
    check("t3_writes", wr_total - base, 3);
    check("t3_wr_left", exp_wr.size(), 0);
    if (wr_cycs.size() == 3) begin
      check("t3_gap", wr_cycs[1] - wr_cycs[0], 2);
      check("t3_consec", wr_cycs[2] - wr_cycs[1], 1);
      check("t3_done_on_last", done_cyc, wr_cycs[2]);
    end else fail("t3_write_count");
    check("t3_busy_at_done", busy_at_done, 0);

    // ---- zero-length command
    repeat (2) tick();
    csbase = cs_cnt; dbase = done_cnt;
    send_cmd(1'b0, 18'h00055, 18'd0);
    check("t4_done", done, 1);
    check("t4_busy", busy, 0);
    check("t4_cmd_ready", cmd_ready, 1);
    tick();
    check("t4_done_pulse", done, 0);
    check("t4_busy2", busy, 0);
    repeat (4) tick();
    check("t4_no_cs", cs_cnt - csbase, 0);
    check("t4_done_once", done_cnt - dbase, 1);

    // ---- reset one cycle after the 3rd issued read of a 10-word read
    rd_ready = 1'b0;
    base = rd_total; dbase = done_cnt;
    send_cmd(1'b0, 18'h00200, 18'd10);
    n = 0;
    while (rd_total - base < 3 && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("t5_three_reads", rd_total - base, 3);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    exp_rd_addr.delete();
    exp_rd_data.delete();
    #1;
    base = rd_total;
    check("t5_rd_valid", rd_valid, 0);
    check("t5_cs", sram_chipselect, 0);
    check("t5_read", sram_read, 0);
    check("t5_addr", sram_address, 0);
    check("t5_cmd_ready", cmd_ready, 1);
    check("t5_busy", busy, 0);
    repeat (10) tick();
    check("t5_no_push", rd_valid, 0);
    check("t5_no_reads", rd_total - base, 0);
    check("t5_no_done", done_cnt - dbase, 0);

    // ---- read of 5 words with a randomly stalling sink
    dbase = done_cnt;
    rd_ready = 1'($urandom_range(0, 1));
    send_cmd(1'b0, 18'h03000, 18'd5);
    n = 0;
    while ((done_cnt <= dbase || exp_rd_data.size() != 0) && n < 300) begin
      n++;
      rd_ready = 1'($urandom_range(0, 1));
      tick();
    end
    check("t6_done", done_cnt - dbase, 1);
    check("t6_drained", exp_rd_data.size(), 0);
    rd_ready = 1'b1;
    repeat (3) tick();

    check("never_rd_and_wr", both_cnt, 0);
    check("cs_matches_access", cs_bad, 0);
    check("rd_addr_left", exp_rd_addr.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
